// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multi-cycle RV32I core: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and owns halt, trap, timeout and instret.
module multicycle_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_dmem_rd_en,
  input  logic             i_dmem_wr_en,
  input  logic             i_rf_wr_req,
  input  logic             i_halt,
  input  logic             i_trap,
  output logic             o_imem_req,
  output logic             o_ir_load,
  output logic             o_dmem_req,
  output logic             o_rf_wr_en,
  output logic             o_pc_wr,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_trapped,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              trapped;
  logic              timed_out;
  logic [CNT_W-1:0]  instret;

  // Strobes decode from the current state and live acks; gating with i_rst keeps a
  // reset that lands mid-instruction from committing anything on that cycle.
  always_comb begin
    o_imem_req = 1'b0;
    o_ir_load  = 1'b0;
    o_dmem_req = 1'b0;
    o_rf_wr_en = 1'b0;
    o_pc_wr    = 1'b0;
    if (!i_rst) begin
      unique case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_load  = i_imem_ready;
        end
        S_MEMORY: begin
          o_dmem_req = 1'b1;
          o_pc_wr    = i_dmem_ready & ~i_dmem_rd_en;
        end
        S_WRITEBACK: begin
          o_rf_wr_en = i_rf_wr_req;
          o_pc_wr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_state   = i_rst ? 3'd0 : 3'(state);
    o_halted  = ~i_rst & (state == S_HALTED);
    o_trapped = ~i_rst & trapped;
    o_timeout = ~i_rst & timed_out;
    o_instret = i_rst ? '0 : instret;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      trapped   <= 1'b0;
      timed_out <= 1'b0;
      instret   <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (i_imem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= S_HALTED;
            timed_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (i_halt || i_trap) begin
            state   <= S_HALTED;
            trapped <= i_trap;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (i_dmem_rd_en && i_dmem_wr_en) begin
            state   <= S_HALTED;
            trapped <= 1'b1;
          end else if (i_dmem_rd_en || i_dmem_wr_en) begin
            state    <= S_MEMORY;
            wait_cnt <= '0;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (i_dmem_ready) begin
            wait_cnt <= '0;
            if (i_dmem_rd_en) begin
              state <= S_WRITEBACK;
            end else begin
              state   <= S_FETCH;
              instret <= instret + 1'b1;
            end
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= S_HALTED;
            timed_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WRITEBACK: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
          instret  <= instret + 1'b1;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table plus hand-written
// sequences for timeouts, halt with trap, and reset during a memory access.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, imem_ready, dmem_ready, rd_en, wr_en, rf_req, halt, trap;
  logic        imem_req, ir_load, dmem_req, rf_wr_en, pc_wr, halted, trapped, timeout;
  logic [2:0]  state;
  logic [31:0] instret;

  int unsigned checks = 0;
  int unsigned failures = 0;

  multicycle_sequencer #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
    .i_dmem_rd_en(rd_en), .i_dmem_wr_en(wr_en), .i_rf_wr_req(rf_req),
    .i_halt(halt), .i_trap(trap),
    .o_imem_req(imem_req), .o_ir_load(ir_load), .o_dmem_req(dmem_req),
    .o_rf_wr_en(rf_wr_en), .o_pc_wr(pc_wr), .o_state(state), .o_halted(halted),
    .o_trapped(trapped), .o_timeout(timeout), .o_instret(instret)
  );

  always #5 clk = ~clk;

  // Input bits {rst, imem_ready, dmem_ready, rd_en, wr_en, rf_req, halt, trap}
  localparam logic [7:0] I_RST  = 8'hFF;
  localparam logic [7:0] I_ALU  = 8'b0110_0100;
  localparam logic [7:0] I_LDW  = 8'b0101_0100;
  localparam logic [7:0] I_LDR  = 8'b0111_0100;
  localparam logic [7:0] I_ST   = 8'b0110_1100;
  localparam logic [7:0] I_STW  = 8'b0100_1100;
  localparam logic [7:0] I_NOI  = 8'b0010_0000;
  localparam logic [7:0] I_ALN  = 8'b0110_0000;
  localparam logic [7:0] I_ILL  = 8'b0111_1000;
  localparam logic [7:0] I_ALL  = 8'b0111_1111;
  localparam logic [7:0] I_HLT  = 8'b0110_0010;
  localparam logic [7:0] I_HT   = 8'b0110_0011;
  // Output bits {imem_req, ir_load, dmem_req, rf_wr_en, pc_wr, halted, trapped, timeout}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_FET  = 8'b1100_0000;
  localparam logic [7:0] O_IMQ  = 8'b1000_0000;
  localparam logic [7:0] O_MRQ  = 8'b0010_0000;
  localparam logic [7:0] O_MST  = 8'b0010_1000;
  localparam logic [7:0] O_WBR  = 8'b0001_1000;
  localparam logic [7:0] O_WBN  = 8'b0000_1000;
  localparam logic [7:0] O_HT   = 8'b0000_0110;
  localparam logic [7:0] O_HH   = 8'b0000_0100;
  localparam logic [7:0] O_HTO  = 8'b0000_0101;

  typedef struct {
    logic [7:0]  in;
    logic [2:0]  st;
    logic [7:0]  outs;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t mk(logic [7:0] in, logic [2:0] st, logic [7:0] outs, logic [31:0] ret);
    vec_t v;
    v.in = in; v.st = st; v.outs = outs; v.ret = ret;
    return v;
  endfunction

  function automatic logic [10:0] obs();
    return {state, imem_req, ir_load, dmem_req, rf_wr_en, pc_wr, halted, trapped, timeout};
  endfunction

  task automatic apply(input logic [7:0] in);
    {rst, imem_ready, dmem_ready, rd_en, wr_en, rf_req, halt, trap} = in;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    apply(I_RST);
    tick();
  endtask

  task automatic run_alu();
    for (int c = 0; c < 4; c++) begin
      apply(I_ALU);
      tick();
    end
  endtask

  initial begin
    int unsigned cnt;

    tbl[0]  = mk(I_RST, 3'd0, O_NONE, 0);
    tbl[1]  = mk(I_ALU, 3'd0, O_FET,  0);
    tbl[2]  = mk(I_ALU, 3'd1, O_NONE, 0);
    tbl[3]  = mk(I_ALU, 3'd2, O_NONE, 0);
    tbl[4]  = mk(I_ALU, 3'd4, O_WBR,  0);
    tbl[5]  = mk(I_LDW, 3'd0, O_FET,  1);
    tbl[6]  = mk(I_LDW, 3'd1, O_NONE, 1);
    tbl[7]  = mk(I_LDW, 3'd2, O_NONE, 1);
    tbl[8]  = mk(I_LDW, 3'd3, O_MRQ,  1);
    tbl[9]  = mk(I_LDW, 3'd3, O_MRQ,  1);
    tbl[10] = mk(I_LDR, 3'd3, O_MRQ,  1);
    tbl[11] = mk(I_LDR, 3'd4, O_WBR,  1);
    tbl[12] = mk(I_ST,  3'd0, O_FET,  2);
    tbl[13] = mk(I_ST,  3'd1, O_NONE, 2);
    tbl[14] = mk(I_ST,  3'd2, O_NONE, 2);
    tbl[15] = mk(I_ST,  3'd3, O_MST,  2);
    tbl[16] = mk(I_NOI, 3'd0, O_IMQ,  3);
    tbl[17] = mk(I_ALN, 3'd0, O_FET,  3);
    tbl[18] = mk(I_ALN, 3'd1, O_NONE, 3);
    tbl[19] = mk(I_ALN, 3'd2, O_NONE, 3);
    tbl[20] = mk(I_ALN, 3'd4, O_WBN,  3);
    tbl[21] = mk(I_ILL, 3'd0, O_FET,  4);
    tbl[22] = mk(I_ILL, 3'd1, O_NONE, 4);
    tbl[23] = mk(I_ILL, 3'd2, O_NONE, 4);
    tbl[24] = mk(I_ALL, 3'd5, O_HT,   4);
    tbl[25] = mk(I_ALL, 3'd5, O_HT,   4);
    tbl[26] = mk(I_RST, 3'd0, O_NONE, 0);
    tbl[27] = mk(I_HLT, 3'd0, O_FET,  0);
    tbl[28] = mk(I_HLT, 3'd1, O_NONE, 0);
    tbl[29] = mk(I_HLT, 3'd5, O_HH,   0);
    tbl[30] = mk(I_RST, 3'd0, O_NONE, 0);

    apply(I_RST);
    tick();
    tick();

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      check($sformatf("vec%0d_outs", i), 32'(obs()), 32'({tbl[i].st, tbl[i].outs}));
      check($sformatf("vec%0d_instret", i), instret, tbl[i].ret);
      tick();
    end

    // Fetch timeout: imem never acks
    do_reset();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      apply(I_NOI);
      if (imem_req) cnt++;
      tick();
    end
    check("imem_timeout_req_cycles", cnt, 4);
    apply(I_NOI);
    check("imem_timeout_outs", 32'(obs()), 32'({3'd5, O_HTO}));

    // Memory timeout: load whose dmem never acks
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(I_LDW);
      tick();
    end
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      apply(I_LDW);
      if (dmem_req) cnt++;
      tick();
    end
    check("dmem_timeout_req_cycles", cnt, 4);
    apply(I_LDW);
    check("dmem_timeout_outs", 32'(obs()), 32'({3'd5, O_HTO}));
    check("dmem_timeout_instret", instret, 0);

    // Halt and trap together after one retired instruction
    do_reset();
    run_alu();
    apply(I_HT);
    tick();
    apply(I_HT);
    tick();
    apply(I_HT);
    check("halt_trap_outs", 32'(obs()), 32'({3'd5, O_HT}));
    check("halt_trap_instret", instret, 1);
    for (int c = 0; c < 20; c++) begin
      logic [7:0] rnd;
      rnd = 8'($urandom);
      rnd[7] = 1'b0;
      rnd[6] = c[0];
      rnd[5] = ~c[0];
      apply(rnd);
      check($sformatf("halted_hold%0d", c), {21'd0, obs()} ^ (instret << 11), {21'd0, 3'd5, O_HT} ^ (32'd1 << 11));
      tick();
    end

    // Reset pulse while a store waits in MEMORY
    do_reset();
    run_alu();
    for (int c = 0; c < 3; c++) begin
      apply(I_ST);
      tick();
    end
    apply(I_STW);
    check("pre_reset_mem_outs", 32'(obs()), 32'({3'd3, O_MRQ}));
    check("pre_reset_instret", instret, 1);
    tick();
    apply(I_RST);
    check("reset_in_mem_outs", 32'(obs()), 32'(0));
    check("reset_in_mem_instret", instret, 0);
    tick();
    apply(I_NOI);
    check("after_reset_outs", 32'(obs()), 32'({3'd0, O_IMQ}));
    check("after_reset_instret", instret, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
